// File: rtl/proc_control_fsm.sv
// Self-sequencing control unit for the multicycle datapath: latches an instruction on run,
// then walks LOAD_A / LOAD_R / WRITE (or OUT / ILL) driving registered one-hot controls.
module proc_control_fsm #(
    parameter  int REG_ADDR_W = 3,
    parameter  int OP_W       = 3,
    localparam int NUM_REGS   = 2 ** REG_ADDR_W,
    localparam int IR_W       = OP_W + 2 * REG_ADDR_W
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                run,
    input  logic [IR_W-1:0]     instr,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [NUM_REGS-1:0] reg_select,
    output logic                imm_select,
    output logic                r_select,
    output logic [NUM_REGS-1:0] reg_enable,
    output logic                a_enable,
    output logic                r_enable,
    output logic                op_select,
    output logic                negate,
    output logic                out_enable
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_R = 3'd2,
        S_WRITE  = 3'd3,
        S_OUT    = 3'd4,
        S_ILL    = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b111;

    state_t                state_reg, state_next;
    logic [IR_W-1:0]       ir_reg, ir_next;
    logic [2:0]            op_in, op_n;
    logic [REG_ADDR_W-1:0] rx_n, ry_n;
    logic [NUM_REGS-1:0]   rx_oh, ry_oh;

    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                illegal_reg, illegal_next;
    logic [NUM_REGS-1:0] reg_select_reg, reg_select_next;
    logic                imm_select_reg, imm_select_next;
    logic                r_select_reg, r_select_next;
    logic [NUM_REGS-1:0] reg_enable_reg, reg_enable_next;
    logic                a_enable_reg, a_enable_next;
    logic                r_enable_reg, r_enable_next;
    logic                op_select_reg, op_select_next;
    logic                negate_reg, negate_next;
    logic                out_enable_reg, out_enable_next;

    // Only the low three opcode bits are decoded; wider opcodes alias onto them.
    assign op_in = instr[2*REG_ADDR_W +: 3];
    assign op_n  = ir_next[2*REG_ADDR_W +: 3];
    assign rx_n  = ir_next[REG_ADDR_W +: REG_ADDR_W];
    assign ry_n  = ir_next[0 +: REG_ADDR_W];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign rx_oh[gi] = (rx_n == REG_ADDR_W'(gi));
            assign ry_oh[gi] = (ry_n == REG_ADDR_W'(gi));
        end
    endgenerate

    // Outputs are decoded from the upcoming state/IR so the registered copies line up
    // with the state they belong to, with no combinational path to the ports.
    always_comb begin
        state_next      = state_reg;
        ir_next         = ir_reg;
        done_next       = 1'b0;
        illegal_next    = 1'b0;
        reg_select_next = '0;
        imm_select_next = 1'b0;
        r_select_next   = 1'b0;
        reg_enable_next = '0;
        a_enable_next   = 1'b0;
        r_enable_next   = 1'b0;
        op_select_next  = 1'b0;
        negate_next     = 1'b0;
        out_enable_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    ir_next = instr;
                    case (op_in)
                        OP_ADD, OP_SUB, OP_NAN, OP_LDI, OP_MOV: state_next = S_LOAD_A;
                        OP_OUT:                                 state_next = S_OUT;
                        default:                                state_next = S_ILL;
                    endcase
                end
            end
            S_LOAD_A: state_next = S_LOAD_R;
            S_LOAD_R: state_next = S_WRITE;
            default:  state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);

        case (state_next)
            S_LOAD_A: begin
                a_enable_next = 1'b1;
                // LDI/MOV leave the bus undriven so A captures zero.
                if (op_n == OP_ADD || op_n == OP_SUB || op_n == OP_NAN)
                    reg_select_next = rx_oh;
            end
            S_LOAD_R: begin
                r_enable_next  = 1'b1;
                op_select_next = (op_n != OP_NAN);
                negate_next    = (op_n == OP_SUB);
                if (op_n == OP_LDI)
                    imm_select_next = 1'b1;
                else
                    reg_select_next = ry_oh;
            end
            S_WRITE: begin
                r_select_next   = 1'b1;
                reg_enable_next = rx_oh;
                done_next       = 1'b1;
            end
            S_OUT: begin
                reg_select_next = rx_oh;
                out_enable_next = 1'b1;
                done_next       = 1'b1;
            end
            S_ILL: begin
                illegal_next = 1'b1;
                done_next    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            ir_reg         <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            illegal_reg    <= 1'b0;
            reg_select_reg <= '0;
            imm_select_reg <= 1'b0;
            r_select_reg   <= 1'b0;
            reg_enable_reg <= '0;
            a_enable_reg   <= 1'b0;
            r_enable_reg   <= 1'b0;
            op_select_reg  <= 1'b0;
            negate_reg     <= 1'b0;
            out_enable_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ir_reg         <= ir_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            illegal_reg    <= illegal_next;
            reg_select_reg <= reg_select_next;
            imm_select_reg <= imm_select_next;
            r_select_reg   <= r_select_next;
            reg_enable_reg <= reg_enable_next;
            a_enable_reg   <= a_enable_next;
            r_enable_reg   <= r_enable_next;
            op_select_reg  <= op_select_next;
            negate_reg     <= negate_next;
            out_enable_reg <= out_enable_next;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign illegal    = illegal_reg;
    assign reg_select = reg_select_reg;
    assign imm_select = imm_select_reg;
    assign r_select   = r_select_reg;
    assign reg_enable = reg_enable_reg;
    assign a_enable   = a_enable_reg;
    assign r_enable   = r_enable_reg;
    assign op_select  = op_select_reg;
    assign negate     = negate_reg;
    assign out_enable = out_enable_reg;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: default 3-bit register index plus a 4-bit instance,
// comparing all outputs each cycle against hand-derived vectors.
module tb_proc_control_fsm;

    logic clock = 1'b0;
    logic resetn;
    logic run, run2;
    logic [8:0]  instr;
    logic [10:0] instr2;

    logic busy, done, illegal, imm_select, r_select, a_enable, r_enable, op_select, negate, out_enable;
    logic [7:0] reg_select, reg_enable;
    logic busy2, done2, illegal2, imm_select2, r_select2, a_enable2, r_enable2, op_select2, negate2, out_enable2;
    logic [15:0] reg_select2, reg_enable2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    proc_control_fsm dut (
        .clock(clock), .resetn(resetn), .run(run), .instr(instr),
        .busy(busy), .done(done), .illegal(illegal), .reg_select(reg_select),
        .imm_select(imm_select), .r_select(r_select), .reg_enable(reg_enable),
        .a_enable(a_enable), .r_enable(r_enable), .op_select(op_select),
        .negate(negate), .out_enable(out_enable)
    );

    proc_control_fsm #(.REG_ADDR_W(4)) dut_wide (
        .clock(clock), .resetn(resetn), .run(run2), .instr(instr2),
        .busy(busy2), .done(done2), .illegal(illegal2), .reg_select(reg_select2),
        .imm_select(imm_select2), .r_select(r_select2), .reg_enable(reg_enable2),
        .a_enable(a_enable2), .r_enable(r_enable2), .op_select(op_select2),
        .negate(negate2), .out_enable(out_enable2)
    );

    // flag order: busy done illegal imm_select r_select a_enable r_enable op_select negate out_enable
    logic [25:0] obs;
    logic [41:0] obs2;
    assign obs  = {busy, done, illegal, imm_select, r_select, a_enable, r_enable, op_select,
                   negate, out_enable, reg_select, reg_enable};
    assign obs2 = {busy2, done2, illegal2, imm_select2, r_select2, a_enable2, r_enable2, op_select2,
                   negate2, out_enable2, reg_select2, reg_enable2};

    localparam logic [9:0] F_IDLE   = 10'b0000000000;
    localparam logic [9:0] F_LA     = 10'b1000010000;
    localparam logic [9:0] F_LR_ADD = 10'b1000001100;
    localparam logic [9:0] F_LR_SUB = 10'b1000001110;
    localparam logic [9:0] F_LR_NAN = 10'b1000001000;
    localparam logic [9:0] F_LR_LDI = 10'b1001001100;
    localparam logic [9:0] F_WR     = 10'b1100100000;
    localparam logic [9:0] F_OUT    = 10'b1100000001;
    localparam logic [9:0] F_ILL    = 10'b1110000000;

    function automatic logic [25:0] ev(logic [9:0] f, logic [7:0] rs, logic [7:0] re);
        return {f, rs, re};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; run = 1'b0; run2 = 1'b0; instr = '0; instr2 = '0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if (obs !== 26'd0 || obs2 !== 42'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h/%h want=0/0", obs, obs2);
        end
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (obs !== 26'd0 || obs2 !== 42'd0) begin
                bad++;
                $display("FAIL reset_idle cyc%0d got=%h/%h want=0/0", i, obs, obs2);
            end
        end
        $display("reset: done");
    endtask

    task automatic test_add();
        logic [25:0] exp_v [4];
        exp_v = '{ev(F_LA, 8'h04, 8'h00), ev(F_LR_ADD, 8'h20, 8'h00),
                  ev(F_WR, 8'h00, 8'h04), ev(F_IDLE, 8'h00, 8'h00)};
        instr = 9'b000_010_101; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            run = 1'b0;
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL add_r2_r5 cyc%0d got=%h want=%h", i, obs, exp_v[i]);
            end
        end
        $display("add r2,r5: done");
    endtask

    task automatic test_same_reg();
        logic [25:0] exp_v [4];
        exp_v = '{ev(F_LA, 8'h08, 8'h00), ev(F_LR_ADD, 8'h08, 8'h00),
                  ev(F_WR, 8'h00, 8'h08), ev(F_IDLE, 8'h00, 8'h00)};
        instr = 9'b000_011_011; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            run = 1'b0;
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL add_r3_r3 cyc%0d got=%h want=%h", i, obs, exp_v[i]);
            end
        end
        $display("add r3,r3: done");
    endtask

    task automatic test_back_to_back();
        logic [25:0] exp_v [8];
        exp_v = '{ev(F_LA, 8'h80, 8'h00), ev(F_LR_SUB, 8'h01, 8'h00),
                  ev(F_WR, 8'h00, 8'h80), ev(F_IDLE, 8'h00, 8'h00),
                  ev(F_LA, 8'h00, 8'h00), ev(F_LR_LDI, 8'h00, 8'h00),
                  ev(F_WR, 8'h00, 8'h08), ev(F_IDLE, 8'h00, 8'h00)};
        instr = 9'b001_111_000; run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) instr = 9'b101_011_000;  // swapped in while SUB is in flight
            if (i == 4) run = 1'b0;
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL b2b_sub_ldi cyc%0d got=%h want=%h", i, obs, exp_v[i]);
            end
        end
        $display("sub r7,r0 + ldi r3: done");
    endtask

    task automatic test_out_ill();
        logic [8:0]  ins   [3];
        logic [25:0] exp_v [3];
        ins   = '{9'b100_110_000, 9'b011_000_000, 9'b110_101_010};
        exp_v = '{ev(F_OUT, 8'h40, 8'h00), ev(F_ILL, 8'h00, 8'h00), ev(F_ILL, 8'h00, 8'h00)};
        for (int k = 0; k < 3; k++) begin
            instr = ins[k]; run = 1'b1;
            tick();
            run = 1'b0;
            total++;
            if (obs !== exp_v[k]) begin
                bad++;
                $display("FAIL out_ill_active instr=%b got=%h want=%h", ins[k], obs, exp_v[k]);
            end
            tick();
            total++;
            if (obs !== 26'd0) begin
                bad++;
                $display("FAIL out_ill_idle instr=%b got=%h want=0", ins[k], obs);
            end
            $display("single-cycle instr %b: done", ins[k]);
        end
    endtask

    task automatic test_abort();
        logic [25:0] exp_v [4];
        instr = 9'b010_001_100; run = 1'b1;
        tick();
        run = 1'b0;
        total++;
        if (obs !== ev(F_LA, 8'h02, 8'h00)) begin
            bad++;
            $display("FAIL nan_load_a got=%h want=%h", obs, ev(F_LA, 8'h02, 8'h00));
        end
        tick();
        total++;
        if (obs !== ev(F_LR_NAN, 8'h10, 8'h00)) begin
            bad++;
            $display("FAIL nan_load_r got=%h want=%h", obs, ev(F_LR_NAN, 8'h10, 8'h00));
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (obs !== 26'd0) begin
            bad++;
            $display("FAIL abort_immediate got=%h want=0", obs);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== 26'd0) begin
                bad++;
                $display("FAIL abort_held cyc%0d got=%h want=0", i, obs);
            end
        end
        resetn = 1'b1;
        tick();
        total++;
        if (obs !== 26'd0) begin
            bad++;
            $display("FAIL abort_release got=%h want=0", obs);
        end
        $display("abort nan r1,r4: done");

        // MOV r5,r2 with run held through the busy cycles: it must not be queued.
        exp_v = '{ev(F_LA, 8'h00, 8'h00), ev(F_LR_ADD, 8'h04, 8'h00),
                  ev(F_WR, 8'h00, 8'h20), ev(F_IDLE, 8'h00, 8'h00)};
        instr = 9'b111_101_010; run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 2) run = 1'b0;
            total++;
            if (obs !== exp_v[i]) begin
                bad++;
                $display("FAIL mov_r5_r2 cyc%0d got=%h want=%h", i, obs, exp_v[i]);
            end
        end
        tick();
        total++;
        if (obs !== 26'd0) begin
            bad++;
            $display("FAIL busy_run_ignored got=%h want=0", obs);
        end
        $display("mov r5,r2 after abort: done");
    endtask

    task automatic test_wide();
        logic [41:0] exp_v [4];
        exp_v = '{{F_LA, 16'h1000, 16'h0000}, {F_LR_ADD, 16'h0008, 16'h0000},
                  {F_WR, 16'h0000, 16'h1000}, {F_IDLE, 16'h0000, 16'h0000}};
        instr2 = 11'b000_1100_0011; run2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            run2 = 1'b0;
            total++;
            if (obs2 !== exp_v[i]) begin
                bad++;
                $display("FAIL wide_add_r12_r3 cyc%0d got=%h want=%h", i, obs2, exp_v[i]);
            end
        end
        $display("wide add r12,r3: done");
    endtask

    initial begin
        test_reset();
        test_add();
        test_same_reg();
        test_back_to_back();
        test_out_ill();
        test_abort();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
